// File: rtl/mips150_io_pkg.sv
// Shared definitions for the MIPS150 memory-mapped IO block: register word
// offsets (byte offset >> 2), the UART state encoding and the RX FIFO depth.
package mips150_io_pkg;

    localparam logic [5:0] IO_TX_STAT = 6'h00;
    localparam logic [5:0] IO_RX_STAT = 6'h01;
    localparam logic [5:0] IO_TX_DATA = 6'h02;
    localparam logic [5:0] IO_RX_DATA = 6'h03;
    localparam logic [5:0] IO_CYC_CNT = 6'h04;
    localparam logic [5:0] IO_INS_CNT = 6'h05;
    localparam logic [5:0] IO_CNT_RST = 6'h06;

    localparam int RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;

endpackage

// File: rtl/io_uart_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling FSM, and a one-cycle
// push pulse with the received byte when the stop bit is valid.
module io_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serialIn,
    output logic [7:0] rxByte,
    output logic       rxPush
);
    import mips150_io_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic sync1, sync2, linePrev;
    uartState_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0] bitIdx, bitIdxNext;
    logic [7:0] shift, shiftNext;
    logic pushNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            linePrev <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            shift    <= '0;
            rxPush   <= 1'b0;
        end else begin
            sync1    <= serialIn;
            sync2    <= sync1;
            linePrev <= sync2;
            state    <= stateNext;
            cnt      <= cntNext;
            bitIdx   <= bitIdxNext;
            shift    <= shiftNext;
            rxPush   <= pushNext;
        end
    end

    assign rxByte = shift;

    // After the half-bit START wait, every later sample lands mid-bit.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt + 1'b1;
        bitIdxNext = bitIdx;
        shiftNext  = shift;
        pushNext   = 1'b0;
        unique case (state)
            IDLE: begin
                cntNext = '0;
                if (linePrev && !sync2) stateNext = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cntNext    = '0;
                    bitIdxNext = '0;
                    stateNext  = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cntNext    = '0;
                    shiftNext  = {sync2, shift[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cntNext   = '0;
                    pushNext  = sync2;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: rtl/mips150_io_ctrl.sv
// MIPS150 memory-mapped IO slave: UART TX/RX, cycle and retired-instruction counters.
// Define MIPS150_IO_RX_FIFO_EN to replace the single-byte RX buffer with a 4-entry FIFO.
module mips150_io_ctrl #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        instr_retire,
    output logic [31:0] rdata,
    input  logic        serial_in,
    output logic        serial_out
);
    import mips150_io_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [5:0] regSel;
    logic wrEn, rdEn, txWrite, cntClear, rxPop, ovrClear;
    logic unusedBits;

    assign regSel     = addr[7:2];
    assign wrEn       = |wr_mask;
    assign rdEn       = rd_en && !wrEn;
    assign txWrite    = wrEn && (regSel == IO_TX_DATA);
    assign cntClear   = wrEn && (regSel == IO_CNT_RST);
    assign rxPop      = rdEn && (regSel == IO_RX_DATA);
    assign ovrClear   = rdEn && (regSel == IO_RX_STAT);
    assign unusedBits = ^{addr[1:0], wdata[31:8]};

    uartState_t txState, txStateNext;
    logic [CW-1:0] txCnt, txCntNext;
    logic [2:0] txBit, txBitNext;
    logic [7:0] txShift, txShiftNext;
    logic txReady;

    assign txReady = (txState == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            txState <= IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
        end else begin
            txState <= txStateNext;
            txCnt   <= txCntNext;
            txBit   <= txBitNext;
            txShift <= txShiftNext;
        end
    end

    // Writes outside IDLE fall through untouched, which silently drops them.
    always_comb begin
        txStateNext = txState;
        txCntNext   = txCnt + 1'b1;
        txBitNext   = txBit;
        txShiftNext = txShift;
        serial_out  = 1'b1;
        unique case (txState)
            IDLE: begin
                txCntNext = '0;
                if (txWrite) begin
                    txShiftNext = wdata[7:0];
                    txBitNext   = '0;
                    txStateNext = START;
                end
            end
            START: begin
                serial_out = 1'b0;
                if (txCnt == LAST) begin
                    txCntNext   = '0;
                    txStateNext = DATA;
                end
            end
            DATA: begin
                serial_out = txShift[0];
                if (txCnt == LAST) begin
                    txCntNext   = '0;
                    txShiftNext = {1'b0, txShift[7:1]};
                    txBitNext   = txBit + 3'd1;
                    if (txBit == 3'd7) txStateNext = STOP;
                end
            end
            STOP: begin
                if (txCnt == LAST) begin
                    txCntNext   = '0;
                    txStateNext = IDLE;
                end
            end
            default: txStateNext = IDLE;
        endcase
    end

    logic [7:0] rxByte;
    logic rxPush;

    io_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uartRx (
        .clk     (clk),
        .rst     (rst),
        .serialIn(serial_in),
        .rxByte  (rxByte),
        .rxPush  (rxPush)
    );

    logic rxValid, popOk, pushOk, rxDrop, overrun;
    logic [7:0] rxHead;

    assign popOk  = rxPop && rxValid;
    assign rxDrop = rxPush && !pushOk;

`ifdef MIPS150_IO_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);
    logic [7:0] fifoMem [RX_FIFO_DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [PW:0] fifoCount;

    assign rxValid = (fifoCount != '0);
    assign rxHead  = fifoMem[rdPtr];
    assign pushOk  = rxPush && ((fifoCount != (PW+1)'(RX_FIFO_DEPTH)) || popOk);

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= rxByte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
            fifoCount <= fifoCount + (PW+1)'(pushOk) - (PW+1)'(popOk);
        end
    end
`else
    logic [7:0] rxBufData;
    logic rxFull;

    assign rxValid = rxFull;
    assign rxHead  = rxBufData;
    assign pushOk  = rxPush && (!rxFull || popOk);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxFull    <= 1'b0;
            rxBufData <= '0;
        end else if (pushOk) begin
            rxFull    <= 1'b1;
            rxBufData <= rxByte;
        end else if (popOk) begin
            rxFull    <= 1'b0;
        end
    end
`endif

    logic [31:0] cycCnt, insCnt, readValue;

    // A dropped byte outranks a same-cycle status read so the loss is never hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            cycCnt  <= '0;
            insCnt  <= '0;
            rdata   <= '0;
        end else begin
            if (rxDrop)        overrun <= 1'b1;
            else if (ovrClear) overrun <= 1'b0;
            cycCnt <= cntClear ? '0 : cycCnt + 32'd1;
            insCnt <= cntClear ? '0 : insCnt + 32'(instr_retire);
            rdata  <= rdEn ? readValue : '0;
        end
    end

    always_comb begin
        readValue = '0;
        case (regSel)
            IO_TX_STAT: readValue = {31'b0, txReady};
            IO_RX_STAT: readValue = {30'b0, overrun, rxValid};
            IO_RX_DATA: readValue = rxValid ? {24'b0, rxHead} : '0;
            IO_CYC_CNT: readValue = cycCnt;
            IO_INS_CNT: readValue = insCnt;
            default:    readValue = '0;
        endcase
    end

endmodule

// File: tb/tb_mips150_io_ctrl.sv
// Self-checking bench for mips150_io_ctrl at CLKS_PER_BIT=10 with random bytes
// checked against a frame/queue reference model.
module tb_mips150_io_ctrl;

`ifdef MIPS150_IO_RX_FIFO_EN
    localparam int MODEL_DEPTH = 4;
`else
    localparam int MODEL_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic [3:0]  wr_mask = '0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic        instr_retire = 1'b0;
    logic [31:0] rdata;
    logic        serial_in = 1'b1;
    logic        serial_out;

    int testsRun = 0;
    int testsFailed = 0;
    byte unsigned rxModel[$];
    bit ovrModel = 1'b0;

    always #5 clk = ~clk;

    mips150_io_ctrl #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wr_mask     (wr_mask),
        .wdata       (wdata),
        .rd_en       (rd_en),
        .instr_retire(instr_retire),
        .rdata       (rdata),
        .serial_in   (serial_in),
        .serial_out  (serial_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One bus cycle starting and ending on a falling edge.
    task automatic applyStimulus(input logic rd, input logic [3:0] mask, input logic [7:0] a, input logic [31:0] d);
        rd_en   = rd;
        wr_mask = mask;
        addr    = a;
        wdata   = d;
        @(negedge clk);
        rd_en   = 1'b0;
        wr_mask = 4'h0;
    endtask

    task automatic readReg(input logic [7:0] a, output logic [31:0] d);
        applyStimulus(1'b1, 4'h0, a, 32'h0);
        d = rdata;
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 4'($urandom_range(1, 15)), a, d);
    endtask

    task automatic txFrame(input logic [7:0] b);
        logic [9:0] frame;
        logic [31:0] d;
        frame = {1'b1, b, 1'b0};
        writeReg(8'h08, {24'($urandom), b});
        for (int j = 0; j < 100; j++) begin
            checkOutput($sformatf("txBit%0d", j / 10), {31'b0, serial_out}, {31'b0, frame[j / 10]});
            if (j == 1) checkOutput("txReadyLow", rdata, 32'h0);
            rd_en   = (j == 0);
            wr_mask = (j == 30) ? 4'hF : 4'h0;
            addr    = (j == 30) ? 8'h08 : 8'h00;
            wdata   = $urandom;
            @(negedge clk);
        end
        rd_en   = 1'b0;
        wr_mask = 4'h0;
        readReg(8'h00, d);
        checkOutput("txReadyBack", d, 32'h1);
        repeat (3) begin
            checkOutput("txIdleLine", {31'b0, serial_out}, 32'h1);
            @(negedge clk);
        end
    endtask

    task automatic rxFrame(input logic [7:0] b, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = frame[i];
            repeat (10) @(negedge clk);
        end
        serial_in = 1'b1;
        repeat (6) @(negedge clk);
        if (stopBit) begin
            if (rxModel.size() < MODEL_DEPTH) rxModel.push_back(b);
            else ovrModel = 1'b1;
        end
    endtask

    task automatic checkStatus(input string tag);
        logic [31:0] d;
        readReg(8'h04, d);
        checkOutput(tag, d, {30'b0, ovrModel, rxModel.size() != 0});
        ovrModel = 1'b0;
    endtask

    task automatic drainCheck(input string tag);
        logic [31:0] d;
        logic [31:0] expected;
        checkStatus({tag, "Stat"});
        repeat (MODEL_DEPTH + 1) begin
            expected = (rxModel.size() != 0) ? {24'b0, rxModel.pop_front()} : 32'h0;
            readReg(8'h0C, d);
            checkOutput({tag, "Data"}, d, expected);
        end
        checkStatus({tag, "Empty"});
    endtask

    initial begin
        logic [31:0] d;
        int retires;

        repeat (2) begin
            @(negedge clk);
            checkOutput("rstSerialOut", {31'b0, serial_out}, 32'h1);
            checkOutput("rstRdata", rdata, 32'h0);
        end
        rst = 1'b0;
        readReg(8'h00, d);
        checkOutput("rstTxStat", d, 32'h1);
        readReg(8'h04, d);
        checkOutput("rstRxStat", d, 32'h0);
        readReg(8'h1C, d);
        checkOutput("unmapped1C", d, 32'h0);
        writeReg(8'h20, $urandom);
        readReg(8'hFC, d);
        checkOutput("unmappedFC", d, 32'h0);
        @(negedge clk);
        checkOutput("rdataIdleZero", rdata, 32'h0);
        applyStimulus(1'b1, 4'h3, 8'h00, 32'h0);
        checkOutput("rdWrCollision", rdata, 32'h0);

        txFrame(8'hA5);
        txFrame(8'($urandom));

        rxFrame(8'h3C, 1'b1);
        drainCheck("rx3C");
        rxFrame(8'($urandom), 1'b0);
        drainCheck("rxBadStop");
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        drainCheck("rxGlitch");
        rxFrame(8'h11, 1'b1);
        rxFrame(8'h22, 1'b1);
        drainCheck("rxPair");
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(1, MODEL_DEPTH + 1))
                rxFrame(8'($urandom), $urandom_range(0, 7) != 0);
            drainCheck($sformatf("rxRand%0d", k));
        end

        instr_retire = 1'b1;
        writeReg(8'h18, $urandom);
        retires = 0;
        for (int i = 0; i < 20; i++) begin
            instr_retire = 1'($urandom_range(0, 1));
            retires += int'(instr_retire);
            @(negedge clk);
        end
        instr_retire = 1'b0;
        readReg(8'h10, d);
        checkOutput("cycAfterClear", d, 32'd20);
        readReg(8'h14, d);
        checkOutput("insCount", d, 32'(retires));
        writeReg(8'h18, 32'h1);
        readReg(8'h10, d);
        checkOutput("cycCleared", d, 32'd0);
        readReg(8'h14, d);
        checkOutput("insCleared", d, 32'd0);

        force dut.cycCnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycCnt;
        readReg(8'h10, d);
        checkOutput("cycMax", d, 32'hFFFF_FFFF);
        readReg(8'h10, d);
        checkOutput("cycWrap", d, 32'h0);

        writeReg(8'h08, $urandom);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midFrameRstLine", {31'b0, serial_out}, 32'h1);
        rst = 1'b0;
        readReg(8'h00, d);
        checkOutput("midFrameRstReady", d, 32'h1);
        checkOutput("midFrameRstIdle", {31'b0, serial_out}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
